// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite initiator.
// State encoding and AXI response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } axi_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// One command in, one AXI transaction out, one response back.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_write,
    output logic                              busy,
    output logic                              timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

    axi_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          write_q, write_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          arvalid_q, arvalid_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;
    logic          rsp_write_q, rsp_write_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          aw_fin, w_fin;
    logic          bready, rready;

    // Next-state, handshake readies and response capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        write_d     = write_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        aw_fin      = 1'b0;
        w_fin       = 1'b0;
        bready      = 1'b0;
        rready      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    write_d   = cmd_write;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = S_WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR_ADDR_DATA: begin
                // A channel is finished once its valid dropped or it handshakes now.
                aw_fin    = !awvalid_q || M_AXI_AWREADY;
                w_fin     = !wvalid_q || M_AXI_WREADY;
                bready    = aw_fin && w_fin;
                awvalid_d = !aw_fin;
                wvalid_d  = !w_fin;
                if (bready && M_AXI_BVALID) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                end else if (bready) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (M_AXI_BVALID) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                end
            end
            S_RD_ADDR: begin
                rready = M_AXI_ARREADY;
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    if (M_AXI_RVALID) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_resp_d  = M_AXI_RRESP;
                        rsp_rdata_d = M_AXI_RDATA;
                        rsp_write_d = 1'b0;
                    end else begin
                        state_d = S_RD_DATA;
                    end
                end
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (M_AXI_RVALID) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_write_d = 1'b0;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Count cycles spent waiting on the slave; flag is sticky until next accept.
        if (state_q != S_IDLE && state_q != S_DONE) begin
            if (cnt_q != TO_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == TO_MAX) begin
                timeout_d = 1'b1;
            end
        end

        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs, all cleared asynchronously.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            write_q     <= write_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_write     = rsp_write_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master.
// Slave side is driven by hand, cycle by cycle.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic        busy;
    logic        timeout;
    logic [8:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [8:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;

    // {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready}
    logic [5:0] hs;
    // {rsp_valid, busy, timeout}
    logic [2:0] st;
    assign hs = {awvalid, wvalid, bready, arvalid, rready, cmd_ready};
    assign st = {rsp_valid, busy, timeout};

    axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(9),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_write    (rsp_write),
        .busy         (busy),
        .timeout      (timeout),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        slave_idle();
        #1;
        total++;
        if (hs !== 6'b000000) begin
            bad++;
            $display("FAIL rst_hs got=%b exp=000000", hs);
        end
        total++;
        if (st !== 3'b000) begin
            bad++;
            $display("FAIL rst_st got=%b exp=000", st);
        end
        total++;
        if ({rsp_rdata, rsp_resp, rsp_write} !== 35'd0) begin
            bad++;
            $display("FAIL rst_rsp got=%h/%b/%b exp=0", rsp_rdata, rsp_resp, rsp_write);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (hs !== 6'b000001) begin
            bad++;
            $display("FAIL rst_idle_hs got=%b exp=000001", hs);
        end
        total++;
        if (st !== 3'b000) begin
            bad++;
            $display("FAIL rst_idle_st got=%b exp=000", st);
        end
    endtask

    task automatic test_write_fast();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 9'h004;
        cmd_wdata = 32'h0000_0064;
        cmd_wstrb = 4'hF;
        awready   = 1'b1;
        wready    = 1'b1;
        bvalid    = 1'b1;
        bresp     = RESP_OKAY;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (hs !== 6'b111000) begin
            bad++;
            $display("FAIL wf_c1_hs got=%b exp=111000", hs);
        end
        total++;
        if ({awaddr, wdata, wstrb} !== {9'h004, 32'h64, 4'hF}) begin
            bad++;
            $display("FAIL wf_c1_bus got=%h/%h/%h exp=004/64/f", awaddr, wdata, wstrb);
        end
        total++;
        if (st !== 3'b010) begin
            bad++;
            $display("FAIL wf_c1_st got=%b exp=010", st);
        end
        tick();
        slave_idle();
        total++;
        if (hs !== 6'b000000) begin
            bad++;
            $display("FAIL wf_c2_hs got=%b exp=000000", hs);
        end
        total++;
        if ({st, rsp_write, rsp_resp, rsp_rdata} !== {3'b110, 1'b1, 2'b00, 32'd0}) begin
            bad++;
            $display("FAIL wf_c2_rsp got=%b/%b/%b/%h exp=110/1/00/0",
                     st, rsp_write, rsp_resp, rsp_rdata);
        end
        tick();
        total++;
        if (st !== 3'b110) begin
            bad++;
            $display("FAIL wf_hold got=%b exp=110", st);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if ({hs, st} !== {6'b000001, 3'b000}) begin
            bad++;
            $display("FAIL wf_ret got=%b/%b exp=000001/000", hs, st);
        end
    endtask

    task automatic test_read_fast();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 9'h004;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h0000_0064;
        rresp     = RESP_OKAY;
        tick();
        cmd_valid = 1'b0;
        total++;
        if ({hs, araddr} !== {6'b000110, 9'h004}) begin
            bad++;
            $display("FAIL rf_c1 got=%b/%h exp=000110/004", hs, araddr);
        end
        tick();
        slave_idle();
        total++;
        if ({st, rsp_write, rsp_resp, rsp_rdata} !== {3'b110, 1'b0, 2'b00, 32'h64}) begin
            bad++;
            $display("FAIL rf_rsp got=%b/%b/%b/%h exp=110/0/00/64",
                     st, rsp_write, rsp_resp, rsp_rdata);
        end
        total++;
        if (hs !== 6'b000000) begin
            bad++;
            $display("FAIL rf_c2_hs got=%b exp=000000", hs);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_slow();
        int nrsp;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 9'h008;
        cmd_wdata = 32'hDEAD_BEEF;
        cmd_wstrb = 4'h3;
        awready   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (hs !== 6'b110000) begin
            bad++;
            $display("FAIL ws_c1 got=%b exp=110000", hs);
        end
        tick();
        awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({hs, wdata, wstrb} !== {6'b010000, 32'hDEAD_BEEF, 4'h3}) begin
                bad++;
                $display("FAIL ws_wwait%0d got=%b/%h/%h exp=010000/deadbeef/3",
                         i, hs, wdata, wstrb);
            end
            tick();
        end
        wready = 1'b1;
        #1;
        total++;
        if (hs !== 6'b011000) begin
            bad++;
            $display("FAIL ws_whs got=%b exp=011000", hs);
        end
        tick();
        wready = 1'b0;
        total++;
        if ({hs, st} !== {6'b001000, 3'b010}) begin
            bad++;
            $display("FAIL ws_bwait got=%b/%b exp=001000/010", hs, st);
        end
        tick();
        bvalid = 1'b1;
        bresp  = RESP_EXOKAY;
        tick();
        slave_idle();
        total++;
        if ({st, rsp_write, rsp_resp} !== {3'b110, 1'b1, 2'b01}) begin
            bad++;
            $display("FAIL ws_rsp got=%b/%b/%b exp=110/1/01", st, rsp_write, rsp_resp);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        nrsp = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid) nrsp++;
            tick();
        end
        total++;
        if (nrsp !== 0) begin
            bad++;
            $display("FAIL ws_extra_rsp got=%0d exp=0", nrsp);
        end
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 9'h010;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        total++;
        if ({arvalid, st} !== {1'b1, 3'b010}) begin
            bad++;
            $display("FAIL to_pre got=%b/%b exp=1/010", arvalid, st);
        end
        tick();
        total++;
        if ({arvalid, st} !== {1'b1, 3'b011}) begin
            bad++;
            $display("FAIL to_set got=%b/%b exp=1/011", arvalid, st);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({arvalid, st} !== {1'b1, 3'b011}) begin
            bad++;
            $display("FAIL to_sticky got=%b/%b exp=1/011", arvalid, st);
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        total++;
        if ({hs, st} !== {6'b000010, 3'b011}) begin
            bad++;
            $display("FAIL to_rdata got=%b/%b exp=000010/011", hs, st);
        end
        rvalid = 1'b1;
        rdata  = 32'hA5A5_0001;
        rresp  = RESP_SLVERR;
        tick();
        slave_idle();
        total++;
        if ({st, rsp_resp, rsp_rdata} !== {3'b111, 2'b10, 32'hA5A5_0001}) begin
            bad++;
            $display("FAIL to_rsp got=%b/%b/%h exp=111/10/a5a50001",
                     st, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if (timeout !== 1'b1) begin
            bad++;
            $display("FAIL to_idle_keep got=%b exp=1", timeout);
        end
        cmd_valid = 1'b1;
        cmd_addr  = 9'h000;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h1;
        tick();
        cmd_valid = 1'b0;
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_clear got=%b exp=0", timeout);
        end
        tick();
        slave_idle();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 9'h00C;
        cmd_wdata = 32'h1234_5678;
        cmd_wstrb = 4'hF;
        awready   = 1'b1;
        wready    = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        total++;
        if ({hs, st} !== {6'b001000, 3'b010}) begin
            bad++;
            $display("FAIL rm_wresp got=%b/%b exp=001000/010", hs, st);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({hs, st} !== {6'b000000, 3'b000}) begin
            bad++;
            $display("FAIL rm_async got=%b/%b exp=000000/000", hs, st);
        end
        bvalid = 1'b1;
        tick();
        tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rm_norsp got=%b exp=0", rsp_valid);
        end
        slave_idle();
        rst_n = 1'b1;
        tick();
        tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 9'h020;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'hCAFE_0020;
        rresp     = RESP_DECERR;
        tick();
        cmd_valid = 1'b0;
        tick();
        slave_idle();
        total++;
        if ({st, rsp_write, rsp_resp, rsp_rdata} !== {3'b110, 1'b0, 2'b11, 32'hCAFE_0020}) begin
            bad++;
            $display("FAIL rm_after got=%b/%b/%b/%h exp=110/0/11/cafe0020",
                     st, rsp_write, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int leaks;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 9'h030;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h0000_0030;
        tick();
        tick();
        slave_idle();
        cmd_write = 1'b1;
        cmd_addr  = 9'h034;
        cmd_wdata = 32'h5555_AAAA;
        cmd_wstrb = 4'hF;
        leaks = 0;
        for (int i = 0; i < 5; i++) begin
            if (hs !== 6'b000000 || rsp_valid !== 1'b1) leaks++;
            tick();
        end
        total++;
        if (leaks !== 0) begin
            bad++;
            $display("FAIL bb_hold got=%0d exp=0 bad cycles", leaks);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        total++;
        if ({hs, rsp_valid} !== {6'b000001, 1'b0}) begin
            bad++;
            $display("FAIL bb_idle got=%b/%b exp=000001/0", hs, rsp_valid);
        end
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        total++;
        if ({hs, awaddr} !== {6'b111000, 9'h034}) begin
            bad++;
            $display("FAIL bb_accept got=%b/%h exp=111000/034", hs, awaddr);
        end
        tick();
        slave_idle();
        total++;
        if ({st, rsp_write} !== {3'b110, 1'b1}) begin
            bad++;
            $display("FAIL bb_rsp got=%b/%b exp=110/1", st, rsp_write);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_read_fast();
        test_write_slow();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
